cost_table_server: RTL and testbench
====================================

COST_TABLE_SERVER -- requirements
Module: cost_table_server

Interface
Parameters:
REQ-001 SHALL provide parameter TIMEOUT, default 600000, max RUN-state cycles before forced completion.
REQ-002 SHALL provide parameter HOLD_CYC, default 2, cycles JamRST stays high after table load completes.
Ports:
REQ-003 SHALL have CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have LdValid  input  1  load word valid.
REQ-006 SHALL have LdData  input  7  cost word, row-major order (index = 8*W+J).
REQ-007 SHALL have LdReady  output  1  load word accepted when LdValid&&LdReady.
REQ-008 SHALL have GoldMinCost  input  10  expected minimum cost.
REQ-009 SHALL have GoldMatchCount  input  4  expected match count.
REQ-010 SHALL have JamRST  output  1  reset driven to the JAM core, active-high.
REQ-011 SHALL have W  input  3  worker index from JAM.
REQ-012 SHALL have J  input  3  job index from JAM.
REQ-013 SHALL have Cost  output  7  cost table entry for (W,J).
REQ-014 SHALL have Valid  input  1  JAM result valid.
REQ-015 SHALL have MinCost  input  10  JAM reported minimum cost.
REQ-016 SHALL have MatchCount  input  4  JAM reported match count.
REQ-017 SHALL have Done  output  1  run finished (result captured or timeout).
REQ-018 SHALL have Pass  output  1  captured result equals golden.
REQ-019 SHALL have Timeout  output  1  run ended by TIMEOUT.
REQ-020 SHALL have CycleCount  output  20  RUN cycles elapsed up to completion.

Function
REQ-021 SHALL implement FSM states LOAD, HOLD, RUN, DONE; reset state LOAD.
REQ-022 LOAD: LdReady=1; each accepted word written to table[ptr], ptr (6-bit) increments; ptr wraps to 0 after the 64th accept while moving to HOLD.
REQ-023 GoldMinCost/GoldMatchCount SHALL be registered on the accept with ptr==0 and held until next reset.
REQ-024 LdReady SHALL be 0 in HOLD, RUN, DONE; LdValid ignored there.
REQ-025 Cost SHALL be combinational table[8*W+J] in every state (zero-latency, same-cycle read); entries not yet loaded read 0.
REQ-026 JamRST SHALL be 1 in LOAD and HOLD, 0 in RUN and DONE.
REQ-027 HOLD SHALL last exactly HOLD_CYC cycles, then go to RUN.
REQ-028 RUN: CycleCount increments by 1 each cycle, starting from 0 on first RUN cycle.
REQ-029 RUN with Valid=1: capture MinCost/MatchCount; next cycle Done=1, Pass=(MinCost==gold && MatchCount==gold), Timeout=0; go to DONE.
REQ-030 RUN with CycleCount==TIMEOUT-1 and Valid=0: next cycle Done=1, Timeout=1, Pass=0; go to DONE.
REQ-031 Valid and timeout in same cycle: Valid wins (REQ-029).
REQ-032 Valid in LOAD or HOLD SHALL be ignored.
REQ-033 DONE SHALL be terminal until RST; Done/Pass/Timeout/CycleCount frozen; later Valid ignored.
REQ-034 Comparison SHALL use full 10-bit MinCost and 4-bit MatchCount, no truncation.

Reset
REQ-035 RST=1 on any cycle, including mid-LOAD or mid-RUN, SHALL next cycle: state LOAD, ptr=0, all 64 table entries=0, gold regs=0, LdReady=1, JamRST=1, Done=0, Pass=0, Timeout=0, CycleCount=0.
REQ-036 While RST=1 no load word SHALL be accepted.

Verification
REQ-037 Load 64 words with LdData=index mod 128, gold=(100,3); W=5,J=3 -> Cost=43 same cycle; JamRST falls exactly 2 cycles after 64th accept.
REQ-038 After load, Valid=1 with MinCost=100, MatchCount=3 on 10th RUN cycle -> next cycle Done=1, Pass=1, Timeout=0, CycleCount=10.
REQ-039 Same with MinCost=101 -> Done=1, Pass=0, Timeout=0.
REQ-040 TIMEOUT=50, never assert Valid -> Done=1, Timeout=1, Pass=0, CycleCount=50; Valid afterwards leaves outputs unchanged.
REQ-041 LdValid toggling every other cycle, RST pulse after 30 accepts -> table all 0, ptr=0; fresh 64-word load completes normally.
REQ-042 TIMEOUT=50, Valid=1 with golden values on cycle CycleCount==49 -> Pass=1, Timeout=0.

Source files
------------

// File: rtl/cost_table_server_if.sv
// Bus bundle between the cost table server and its environment:
// table load stream, golden values, JAM-side lookup/result and run status.
interface cost_table_server_if;
    logic        LdValid;
    logic [6:0]  LdData;
    logic        LdReady;
    logic [9:0]  GoldMinCost;
    logic [3:0]  GoldMatchCount;
    logic        JamRST;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic        Valid;
    logic [9:0]  MinCost;
    logic [3:0]  MatchCount;
    logic        Done;
    logic        Pass;
    logic        Timeout;
    logic [19:0] CycleCount;

    // Server side of the bundle.
    modport slave (
        input  LdValid, LdData, GoldMinCost, GoldMatchCount, W, J, Valid, MinCost, MatchCount,
        output LdReady, JamRST, Cost, Done, Pass, Timeout, CycleCount
    );

    // Environment side of the bundle.
    modport master (
        output LdValid, LdData, GoldMinCost, GoldMatchCount, W, J, Valid, MinCost, MatchCount,
        input  LdReady, JamRST, Cost, Done, Pass, Timeout, CycleCount
    );
endinterface

// File: rtl/cost_table_server.sv
// Cost table server for a JAM (job assignment) core: loads a 64-entry
// 8x8 cost table, holds the core in reset briefly, serves zero-latency
// cost lookups while the core runs, and grades the core's result against
// golden values (or flags a timeout).
module cost_table_server #(
    parameter int TIMEOUT  = 600000,
    parameter int HOLD_CYC = 2
) (
    input logic                CLK,
    input logic                RST,
    cost_table_server_if.slave bus
);
    localparam int                HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [19:0]       RUN_LAST  = 20'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [6:0]        table_mem [64];
    logic [5:0]        ptr;
    logic [9:0]        gold_min;
    logic [3:0]        gold_match;
    logic [HOLD_W-1:0] hold_cnt;
    logic [19:0]       cycle_count;
    logic              done;
    logic              pass;
    logic              timeout;
    logic              accept;

    // Loading is refused while reset is asserted, even in LOAD.
    assign bus.LdReady = (state == S_LOAD) && !RST;
    assign accept      = bus.LdValid && bus.LdReady;

    // The JAM core is held in reset until the table is loaded and settled.
    assign bus.JamRST = (state == S_LOAD) || (state == S_HOLD);

    // Same-cycle table lookup; row-major index 8*W+J.
    assign bus.Cost = table_mem[{bus.W, bus.J}];

    assign bus.Done       = done;
    assign bus.Pass       = pass;
    assign bus.Timeout    = timeout;
    assign bus.CycleCount = cycle_count;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: LOAD -> HOLD -> RUN -> DONE, DONE is terminal.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (accept && (ptr == 6'd63)) state_nxt = S_HOLD;
            S_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
            S_RUN:  if (bus.Valid || (cycle_count == RUN_LAST)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_LOAD;
        endcase
    end

    // Cost table storage; cleared on reset so unloaded entries read zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 64; i++) begin
                table_mem[i] <= '0;
            end
        end else if (accept) begin
            table_mem[ptr] <= bus.LdData;
        end
    end

    // Write pointer (wraps to 0 after the 64th word) and golden values,
    // which are latched with the first word of the load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr        <= '0;
            gold_min   <= '0;
            gold_match <= '0;
        end else if (accept) begin
            ptr <= ptr + 6'd1;
            if (ptr == 6'd0) begin
                gold_min   <= bus.GoldMinCost;
                gold_match <= bus.GoldMatchCount;
            end
        end
    end

    // Counts HOLD cycles; idles at zero in every other state.
    always_ff @(posedge CLK) begin
        if (RST || (state != S_HOLD)) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Run bookkeeping: cycle count, result grading or timeout; all frozen in DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
        end else if (state == S_RUN) begin
            cycle_count <= cycle_count + 20'd1;
            if (bus.Valid) begin
                done    <= 1'b1;
                pass    <= (bus.MinCost == gold_min) && (bus.MatchCount == gold_match);
                timeout <= 1'b0;
            end else if (cycle_count == RUN_LAST) begin
                done    <= 1'b1;
                pass    <= 1'b0;
                timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cost_table_server.sv
// Bench for cost_table_server: table-driven run scenarios, cost lookup
// vectors, reset corner sequences and randomized loads/runs checked
// against a behavioural model of the table and grading rules.
module tb_cost_table_server;
    localparam int TO = 50;
    localparam int HC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cost_table_server_if bus ();

    cost_table_server #(.TIMEOUT(TO), .HOLD_CYC(HC)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: table contents, next load slot, golden values.
    logic [6:0] m_tab [64];
    int         m_ptr;
    logic [9:0] m_gmin;
    logic [3:0] m_gmatch;

    typedef struct {
        int          vc;      // CycleCount value on which Valid is raised (>= TO: never)
        logic [9:0]  mc;
        logic [3:0]  mm;
        logic        e_pass;
        logic        e_to;
        logic [19:0] e_cnt;
    } scen_t;

    typedef struct {
        logic [2:0] w;
        logic [2:0] j;
        logic [6:0] e_cost;
    } cv_t;

    scen_t scen [8];
    cv_t   cvec [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.LdValid = 1'b0;
        bus.LdData = '0;
        bus.GoldMinCost = '0;
        bus.GoldMatchCount = '0;
        bus.W = '0;
        bus.J = '0;
        bus.Valid = 1'b0;
        bus.MinCost = '0;
        bus.MatchCount = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_tab[i] = '0;
        m_ptr = 0;
        m_gmin = '0;
        m_gmatch = '0;
    endtask

    task automatic check_zero_table(input string name);
        logic [5:0] idx;
        for (int i = 0; i < 64; i++) begin
            idx = 6'(i);
            bus.W = idx[5:3];
            bus.J = idx[2:0];
            #1;
            chk(name, bus.Cost, 0);
        end
    endtask

    // One reset pulse with a load word offered during it; checks the post-reset outputs.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.LdValid = 1'b1;
        bus.LdData = 7'h7f;
        bus.Valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        model_clear();
        #1;
        chk("rst_ldready", bus.LdReady, 1);
        chk("rst_jamrst", bus.JamRST, 1);
        chk("rst_done", bus.Done, 0);
        chk("rst_pass", bus.Pass, 0);
        chk("rst_timeout", bus.Timeout, 0);
        chk("rst_count", bus.CycleCount, 0);
    endtask

    // Offers words until n are accepted; data is index or random, gold is
    // presented only alongside the first word of the load.
    task automatic load_words(input int n, input bit gaps, input bit rnd,
                              input logic [9:0] gmin, input logic [3:0] gmatch);
        int acc = 0;
        int cyc = 0;
        while (acc < n) begin
            @(negedge clk);
            bus.LdValid = gaps ? (cyc % 2 == 0) : 1'b1;
            bus.LdData = rnd ? 7'($urandom) : 7'(m_ptr % 128);
            if (m_ptr == 0) begin
                bus.GoldMinCost = gmin;
                bus.GoldMatchCount = gmatch;
            end else begin
                bus.GoldMinCost = 10'($urandom);
                bus.GoldMatchCount = 4'($urandom);
            end
            bus.Valid = 1'($urandom);
            bus.MinCost = 10'($urandom);
            bus.W = 3'($urandom);
            bus.J = 3'($urandom);
            #1;
            chk("ld_ready", bus.LdReady, 1);
            chk("ld_jamrst", bus.JamRST, 1);
            chk("ld_cost", bus.Cost, m_tab[{bus.W, bus.J}]);
            @(posedge clk);
            if (bus.LdValid) begin
                m_tab[m_ptr] = bus.LdData;
                if (m_ptr == 0) begin
                    m_gmin = bus.GoldMinCost;
                    m_gmatch = bus.GoldMatchCount;
                end
                m_ptr = (m_ptr + 1) % 64;
                acc++;
            end
            cyc++;
        end
    endtask

    // Expected outcome of a run from the grading rules.
    task automatic expect_result(input int vc, input logic [9:0] mc, input logic [3:0] mm,
                                 output logic e_pass, output logic e_to, output logic [19:0] e_cnt);
        if (vc < TO) begin
            e_pass = (mc == m_gmin) && (mm == m_gmatch);
            e_to = 1'b0;
            e_cnt = 20'(vc + 1);
        end else begin
            e_pass = 1'b0;
            e_to = 1'b1;
            e_cnt = 20'(TO);
        end
    endtask

    // HOLD phase (load and Valid offered but must be ignored), RUN phase, then DONE freeze.
    task automatic hold_and_run(input int vc, input logic [9:0] mc, input logic [3:0] mm,
                                input logic e_pass, input logic e_to, input logic [19:0] e_cnt);
        int c = 0;
        bit fin = 0;
        for (int h = 0; h < HC; h++) begin
            @(negedge clk);
            bus.LdValid = 1'b1;
            bus.LdData = 7'($urandom);
            bus.Valid = 1'b1;
            bus.MinCost = m_gmin;
            bus.MatchCount = m_gmatch;
            #1;
            chk("hold_jamrst", bus.JamRST, 1);
            chk("hold_ldready", bus.LdReady, 0);
            @(posedge clk);
        end
        while (!fin) begin
            @(negedge clk);
            bus.LdValid = 1'($urandom);
            bus.Valid = (c == vc);
            bus.MinCost = (c == vc) ? mc : 10'($urandom);
            bus.MatchCount = (c == vc) ? mm : 4'($urandom);
            bus.W = 3'($urandom);
            bus.J = 3'($urandom);
            #1;
            chk("run_jamrst", bus.JamRST, 0);
            chk("run_count", bus.CycleCount, c);
            chk("run_done", bus.Done, 0);
            chk("run_cost", bus.Cost, m_tab[{bus.W, bus.J}]);
            @(posedge clk);
            if (c == vc || c == TO - 1) fin = 1;
            c++;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.Valid = (k != 0);
            bus.MinCost = e_pass ? 10'($urandom) : m_gmin;
            bus.MatchCount = e_pass ? 4'($urandom) : m_gmatch;
            bus.LdValid = 1'b1;
            bus.LdData = 7'($urandom);
            bus.W = 3'($urandom);
            bus.J = 3'($urandom);
            #1;
            chk("done_done", bus.Done, 1);
            chk("done_pass", bus.Pass, e_pass);
            chk("done_timeout", bus.Timeout, e_to);
            chk("done_count", bus.CycleCount, e_cnt);
            chk("done_ldready", bus.LdReady, 0);
            chk("done_jamrst", bus.JamRST, 0);
            chk("done_cost", bus.Cost, m_tab[{bus.W, bus.J}]);
            @(posedge clk);
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ep;
        logic       et;
        logic [19:0] ec;
        int          vc;
        logic [9:0]  mc;
        logic [3:0]  mm;
        logic [9:0]  gmin;
        logic [3:0]  gmatch;

        scen[0] = '{9,    10'd100, 4'd3,  1'b1, 1'b0, 20'd10};
        scen[1] = '{9,    10'd101, 4'd3,  1'b0, 1'b0, 20'd10};
        scen[2] = '{1000, 10'd0,   4'd0,  1'b0, 1'b1, 20'd50};
        scen[3] = '{49,   10'd100, 4'd3,  1'b1, 1'b0, 20'd50};
        scen[4] = '{0,    10'd100, 4'd3,  1'b1, 1'b0, 20'd1};
        scen[5] = '{20,   10'd612, 4'd3,  1'b0, 1'b0, 20'd21};
        scen[6] = '{20,   10'd100, 4'd11, 1'b0, 1'b0, 20'd21};
        scen[7] = '{48,   10'd100, 4'd2,  1'b0, 1'b0, 20'd49};

        cvec[0] = '{3'd5, 3'd3, 7'd43};
        cvec[1] = '{3'd0, 3'd0, 7'd0};
        cvec[2] = '{3'd7, 3'd7, 7'd63};
        cvec[3] = '{3'd2, 3'd6, 7'd22};
        cvec[4] = '{3'd4, 3'd1, 7'd33};
        cvec[5] = '{3'd1, 3'd0, 7'd8};

        drive_idle();

        // Table-driven run scenarios, each on a fresh index-pattern load with gold (100,3).
        for (int s = 0; s < 8; s++) begin
            reset_dut();
            load_words(64, 1'b0, 1'b0, 10'd100, 4'd3);
            hold_and_run(scen[s].vc, scen[s].mc, scen[s].mm,
                         scen[s].e_pass, scen[s].e_to, scen[s].e_cnt);
            if (s == 0) begin
                for (int v = 0; v < 6; v++) begin
                    bus.W = cvec[v].w;
                    bus.J = cvec[v].j;
                    #1;
                    chk("cost_vec", bus.Cost, cvec[v].e_cost);
                end
            end
        end

        // Reset after 30 gapped accepts, then a fresh full load and run.
        reset_dut();
        load_words(30, 1'b1, 1'b0, 10'd100, 4'd3);
        reset_dut();
        check_zero_table("rst_mid_load_tab");
        load_words(64, 1'b0, 1'b0, 10'd100, 4'd3);
        hold_and_run(9, 10'd100, 4'd3, 1'b1, 1'b0, 20'd10);

        // Reset in the middle of RUN.
        reset_dut();
        load_words(64, 1'b0, 1'b1, 10'($urandom), 4'($urandom));
        @(negedge clk);
        drive_idle();
        repeat (HC + 6) @(posedge clk);
        @(negedge clk);
        #1;
        chk("mid_run_count", bus.CycleCount, 6);
        reset_dut();
        check_zero_table("rst_mid_run_tab");

        // Randomized loads, gold values and run outcomes.
        for (int r = 0; r < 8; r++) begin
            gmin = 10'($urandom);
            gmatch = 4'($urandom);
            reset_dut();
            load_words(64, 1'($urandom), 1'b1, gmin, gmatch);
            vc = $urandom_range(0, TO + 10);
            mc = ($urandom_range(0, 1) == 1) ? m_gmin : 10'($urandom);
            mm = ($urandom_range(0, 3) != 0) ? m_gmatch : 4'($urandom);
            expect_result(vc, mc, mm, ep, et, ec);
            hold_and_run(vc, mc, mm, ep, et, ec);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
